// File: rtl/serial_rx_8b.sv
// serial_rx_8b: receive end of the bit-banged serial port.
// Deserialises an idle-high line (1 start bit, 8 data bits LSB first,
// 1 stop bit, CLKS_PER_BIT clocks per bit) into bytes. The received byte is
// held in a one-entry buffer with a valid/ack handshake toward the host.
module serial_rx_8b #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clock,
  input  logic       nclear,
  input  logic       serial_in,
  input  logic       rd_ack,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  // Encodings kept identical to the legacy localparam values.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            byte_done;
  logic            s_meta;
  logic            s_sync;
  logic            bit_sample;
  logic            stop_bad;

  assign bit_sample = (cnt == BIT_LAST);
  assign stop_bad   = (state == STOP) && bit_sample && !s_sync;
  assign busy       = (state != IDLE);

  // Two-flop synchroniser, preset to the idle level so release of reset
  // never looks like a start bit.
  always_ff @(posedge clock or negedge nclear) begin
    if (!nclear) begin
      s_meta <= 1'b1;
      s_sync <= 1'b1;
    end else begin
      s_meta <= serial_in;
      s_sync <= s_meta;
    end
  end

  // Frame FSM: start validation at mid-bit, data/stop sampling one bit apart.
  always_ff @(posedge clock or negedge nclear) begin
    if (!nclear) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!s_sync) state <= START;
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (s_sync) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_sample) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= s_sync;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_sample) begin
            cnt <= '0;
            if (s_sync) begin
              byte_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= WAIT_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          cnt <= '0;
          if (s_sync) state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Host buffer: deliver completed byte one clock after the stop sample,
  // drop it (and flag overrun) if the previous byte is still unacknowledged.
  always_ff @(posedge clock or negedge nclear) begin
    if (!nclear) begin
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (byte_done) begin
      if (!data_valid || rd_ack) begin
        data_out   <= shift_reg;
        data_valid <= 1'b1;
        if (rd_ack) overrun <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (rd_ack) begin
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

  // Sticky framing error; a new error wins over a simultaneous acknowledge.
  always_ff @(posedge clock or negedge nclear) begin
    if (!nclear)      frame_err <= 1'b0;
    else if (stop_bad) frame_err <= 1'b1;
    else if (rd_ack)   frame_err <= 1'b0;
  end

endmodule

// File: tb/tb_serial_rx_8b.sv
// Bench for serial_rx_8b: three instances (4, 2 and 7 clocks per bit) driven
// by directed frames; delivered bytes go through a scoreboard queue checked
// by an independent monitor, flags are checked inline.
module tb_serial_rx_8b;

  localparam int NI = 3;

  logic       clock = 1'b0;
  logic       nclear;
  logic       ser  [NI];
  logic       ack  [NI];
  logic [7:0] dout [NI];
  logic       dv   [NI];
  logic       fe   [NI];
  logic       ov   [NI];
  logic       bsy  [NI];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];

  logic       prev_dv [NI];
  logic [7:0] prev_do [NI];

  always #5 clock = ~clock;

  serial_rx_8b #(.CLKS_PER_BIT(4)) u_rx4 (
    .clock(clock), .nclear(nclear), .serial_in(ser[0]), .rd_ack(ack[0]),
    .data_out(dout[0]), .data_valid(dv[0]), .frame_err(fe[0]),
    .overrun(ov[0]), .busy(bsy[0]));

  serial_rx_8b #(.CLKS_PER_BIT(2)) u_rx2 (
    .clock(clock), .nclear(nclear), .serial_in(ser[1]), .rd_ack(ack[1]),
    .data_out(dout[1]), .data_valid(dv[1]), .frame_err(fe[1]),
    .overrun(ov[1]), .busy(bsy[1]));

  serial_rx_8b #(.CLKS_PER_BIT(7)) u_rx7 (
    .clock(clock), .nclear(nclear), .serial_in(ser[2]), .rd_ack(ack[2]),
    .data_out(dout[2]), .data_valid(dv[2]), .frame_err(fe[2]),
    .overrun(ov[2]), .busy(bsy[2]));

  function automatic int cpb_of(input int i);
    case (i)
      0:       return 4;
      1:       return 2;
      default: return 7;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [7:0] b);
    case (i)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
  endtask

  // Drive one frame: start bit, 8 data bits LSB first, stop bit.
  task automatic send_frame(input int i, input logic [7:0] b, input logic stop);
    int c;
    logic [9:0] f;
    c = cpb_of(i);
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      ser[i] = f[k];
      repeat (c) @(negedge clock);
    end
  endtask

  task automatic pulse_ack(input int i);
    ack[i] = 1'b1;
    @(negedge clock);
    ack[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Two back-to-back frames, ack held exactly on the completion clock of
  // the second (stop sample lands 3+HALF+9*CPB negedges after frame start).
  task automatic b2b(input int i);
    int c;
    int h;
    c = cpb_of(i);
    h = c / 2;
    push_exp(i, 8'h55);
    push_exp(i, 8'hAA);
    send_frame(i, 8'h55, 1'b1);
    fork
      send_frame(i, 8'hAA, 1'b1);
      begin
        repeat (3 + h + 9 * c) @(negedge clock);
        ack[i] = 1'b1;
        @(negedge clock);
        ack[i] = 1'b0;
      end
    join
    idle(c + 6);
    check($sformatf("b2b%0d data_out", c), dout[i], 8'hAA);
    check($sformatf("b2b%0d data_valid", c), dv[i], 1);
    check($sformatf("b2b%0d overrun", c), ov[i], 0);
    pulse_ack(i);
    check($sformatf("b2b%0d dv after ack", c), dv[i], 0);
  endtask

  // Scoreboard monitor: every new byte presented on the buffer must match
  // the head of that instance's expected queue.
  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      if (nclear === 1'b1 && dv[i] === 1'b1 &&
          (prev_dv[i] !== 1'b1 || dout[i] !== prev_do[i])) begin
        logic [7:0] e;
        logic       got;
        got = 1'b0;
        e   = 8'h00;
        case (i)
          0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
          1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
        endcase
        if (got) begin
          check($sformatf("rx%0d byte", cpb_of(i)), dout[i], e);
        end else begin
          n_vec++;
          n_err++;
          $display("FAIL rx%0d unexpected byte: got %0h, expected none", cpb_of(i), dout[i]);
        end
      end
      prev_dv[i] = dv[i];
      prev_do[i] = dout[i];
    end
  end

  initial begin
    #500000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    nclear = 1'b0;
    for (int i = 0; i < NI; i++) begin
      ser[i] = 1'b1;
      ack[i] = 1'b0;
    end
    idle(3);
    for (int i = 0; i < NI; i++) begin
      check("reset data_out", dout[i], 0);
      check("reset data_valid", dv[i], 0);
      check("reset frame_err", fe[i], 0);
      check("reset overrun", ov[i], 0);
      check("reset busy", bsy[i], 0);
    end
    nclear = 1'b1;
    idle(2);

    // Reset in the middle of a data bit.
    ser[0] = 1'b0;
    idle(14);
    check("pre-reset busy", bsy[0], 1);
    nclear = 1'b0;
    ser[0] = 1'b1;
    @(negedge clock);
    check("midreset busy", bsy[0], 0);
    check("midreset data_valid", dv[0], 0);
    check("midreset data_out", dout[0], 0);
    check("midreset frame_err", fe[0], 0);
    check("midreset overrun", ov[0], 0);
    nclear = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clock);
      check("quiet busy", bsy[0], 0);
      check("quiet data_valid", dv[0], 0);
    end
    check("quiet frame_err", fe[0], 0);

    // 0xA5 with exact completion latency.
    push_exp(0, 8'hA5);
    fork
      send_frame(0, 8'hA5, 1'b1);
      begin
        repeat (3 + 2 + 36) @(negedge clock);
        check("a5 dv at stop sample", dv[0], 0);
        @(negedge clock);
        check("a5 dv one clock later", dv[0], 1);
        check("a5 data_out", dout[0], 8'hA5);
      end
    join
    idle(4);
    check("a5 frame_err", fe[0], 0);
    check("a5 overrun", ov[0], 0);
    pulse_ack(0);
    check("a5 dv after ack", dv[0], 0);
    check("a5 data_out kept", dout[0], 8'hA5);
    pulse_ack(0);
    check("idle ack dv", dv[0], 0);
    check("idle ack data_out", dout[0], 8'hA5);
    check("idle ack frame_err", fe[0], 0);

    // One-clock start glitch.
    ser[0] = 1'b0;
    @(negedge clock);
    ser[0] = 1'b1;
    idle(2);
    check("glitch start seen", bsy[0], 1);
    idle(10);
    check("glitch busy", bsy[0], 0);
    check("glitch data_valid", dv[0], 0);
    check("glitch frame_err", fe[0], 0);

    // Framing error with line stuck low, then recovery.
    send_frame(0, 8'h3C, 1'b0);
    idle(20);
    check("ferr frame_err", fe[0], 1);
    check("ferr data_valid", dv[0], 0);
    check("ferr busy", bsy[0], 1);
    ser[0] = 1'b1;
    idle(5);
    check("ferr released busy", bsy[0], 0);
    push_exp(0, 8'h81);
    send_frame(0, 8'h81, 1'b1);
    idle(8);
    check("0x81 data_valid", dv[0], 1);
    check("0x81 data_out", dout[0], 8'h81);
    check("0x81 frame_err sticky", fe[0], 1);
    pulse_ack(0);
    check("ferr ack frame_err", fe[0], 0);
    check("ferr ack data_valid", dv[0], 0);

    // Overrun: second byte dropped while first is pending.
    push_exp(0, 8'h11);
    send_frame(0, 8'h11, 1'b1);
    idle(6);
    send_frame(0, 8'h22, 1'b1);
    idle(8);
    check("ovr overrun", ov[0], 1);
    check("ovr data_out", dout[0], 8'h11);
    check("ovr data_valid", dv[0], 1);
    pulse_ack(0);
    check("ovr ack data_valid", dv[0], 0);
    check("ovr ack overrun", ov[0], 0);

    // Back-to-back with ack on completion clock at each bit length.
    for (int i = 0; i < NI; i++) begin
      b2b(i);
    end

    idle(4);
    check("rx4 queue drained", q0.size(), 0);
    check("rx2 queue drained", q1.size(), 0);
    check("rx7 queue drained", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
